mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port mem instance between NUM_REQ requesters.
- Each requester issues one read or write over a req/ack handshake.
- The arbiter selects a winner and drives the mem addr/wr_rd/wr_data pins.
- For reads, it waits the mem read latency and then returns rd_data with ack.
- Sits between the requester agents/engines and the mem in the top-level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, mem address width.
- DATA_W, 8, mem data width.
- RD_LAT, 1, cycles from read address presented to mem rd_data valid (1..4).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- req  input  NUM_REQ  per-requester request; held with its fields until ack.
- req_wr_rd  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wr_data  input  NUM_REQ*DATA_W  packed write data; same packing.
- gnt  output  NUM_REQ  one-hot owner; held from ISSUE through completion.
- ack  output  NUM_REQ  one-cycle completion pulse to the owner.
- rsp_rd_data  output  DATA_W  read data; valid only in the ack cycle of a read.
- busy  output  1  high in any state other than IDLE.
- mem_addr  output  ADDR_W  to mem addr.
- mem_wr_rd  output  1  to mem wr_rd (1 = write).
- mem_wr_data  output  DATA_W  to mem wr_data.
- mem_rd_data  input  DATA_W  from mem rd_data.

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE and the round-robin pointer to 0.
  - gnt, ack, rsp_rd_data, busy, mem_addr, mem_wr_rd and mem_wr_data are all 0.
  - Reset mid-transaction aborts it with no ack. A write already in ISSUE may have been committed by mem; this is accepted.
- All outputs are registered.
- The FSM has four states: IDLE, ISSUE, RD_WAIT and RD_DONE.
- IDLE:
  - If req is nonzero, pick the first set bit searching upward from the pointer, wrapping at NUM_REQ.
  - Latch that requester's op, addr and wr_data; set gnt one-hot; go to ISSUE.
  - If req is zero, stay in IDLE with mem_wr_rd=0.
- ISSUE (exactly 1 cycle): mem_addr, mem_wr_rd and mem_wr_data carry the latched values.
  - Write: ack[owner] pulses in this cycle, the pointer becomes (owner+1) mod NUM_REQ, and the next state is IDLE. The mem samples the write at the posedge ending ISSUE.
  - Read: load the latency counter with RD_LAT-1 and go to RD_WAIT.
- RD_WAIT:
  - mem_addr is held and mem_wr_rd=0; the counter decrements each cycle.
  - When the counter is 0, capture mem_rd_data and go to RD_DONE.
- RD_DONE (1 cycle):
  - ack[owner]=1 and rsp_rd_data = captured data.
  - Pointer becomes (owner+1) mod NUM_REQ; next state is IDLE.
- gnt clears on the cycle after ack. mem_wr_rd returns to 0 after ISSUE.
- Latency from req high in IDLE to ack:
  - write: 2 cycles.
  - read: RD_LAT+3 cycles.
- Handshake rules:
  - A requester must keep req and its fields stable until ack.
  - Req still high in the IDLE cycle after ack counts as a new transaction.
  - Requests arriving while busy wait; they are never dropped.
- Fairness: with all requesters continuously active, each is granted once per NUM_REQ transactions.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority.
- Changes to non-owner req lines during a transaction have no effect until IDLE.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQ] and parameter MAX_LOCK (default 4).
  - If the owner's req_lock is high in its ack cycle, the pointer is not advanced, so the owner wins the next IDLE if it is still requesting.
  - A lock-run counter limits this to MAX_LOCK consecutive grants. After that the pointer advances normally and the counter clears.
  - The counter also clears on any grant to a different requester.
- Undefined: the port and parameter do not exist, and the behaviour is pure round-robin.

Test Plan:
- Reset, then requester 0 writes addr=3 data=0xA5:
  - mem_wr_rd=1, mem_addr=3, mem_wr_data=0xA5 for one cycle.
  - ack[0] arrives 2 cycles after req.
- Requester 2 then reads addr=3 with RD_LAT=1:
  - rsp_rd_data=0xA5 with ack[2] four cycles after req.
  - gnt=4'b0100 during the transaction.
- All four req high continuously, mixed ops:
  - Grant order is 0,1,2,3,0,1; no requester receives two grants before all others have had one.
- Pointer at 2; req[1] and req[3] rise in the same cycle:
  - 3 is granted first, then 1.
- Assert rst=0 during RD_WAIT of a read:
  - No ack; all outputs are 0 the next cycle.
  - After release, a pending req[0] is served first.
- With MEM_ARB_LOCK_EN and MAX_LOCK=2: requester 1 holds req and req_lock while requester 2 requests:
  - Grants are 1,1,2.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer sharing one single-port mem
// between NUM_REQ requesters over a req/ack handshake.
// Optional lock feature: define MEM_ARB_LOCK_EN to add req_lock and MAX_LOCK,
// which let an owner keep the pointer for up to MAX_LOCK consecutive grants.
// All outputs are registered. Reset is synchronous, active-low, on rst.
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1
`ifdef MEM_ARB_LOCK_EN
  ,
  parameter int MAX_LOCK = 4
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr_rd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_rd_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr_rd,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic [DATA_W-1:0]         mem_rd_data
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef MEM_ARB_LOCK_EN
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_RD_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                op_wr_q, op_wr_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wr_rd_q, mem_wr_rd_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
`ifdef MEM_ARB_LOCK_EN
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
`endif

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  logic [PTR_W-1:0]    cand;
  logic [PTR_W-1:0]    win_idx;
  logic                win_valid;
  logic                complete;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + PTR_W'(1);
  endfunction

  // Unpack the flat per-requester address and write-data buses.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_wr_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: first set req bit at or above the pointer, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    op_wr_d       = op_wr_q;
    rd_cnt_d      = rd_cnt_q;
    rd_data_d     = rd_data_q;
    gnt_d         = gnt_q;
    ack_d         = '0;
    rsp_d         = '0;
    mem_addr_d    = mem_addr_q;
    mem_wr_rd_d   = 1'b0;
    mem_wr_data_d = mem_wr_data_q;
    complete      = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    lock_cnt_d    = lock_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        // The IDLE cycle that shows ack still sees the old owner's req; it is
        // not arbitrated so the owner can drop req without a spurious grant.
        if (ack_q == '0 && win_valid) begin
          owner_d          = win_idx;
          op_wr_d          = req_wr_rd[win_idx];
          gnt_d[win_idx]   = 1'b1;
          mem_addr_d       = addr_arr[win_idx];
          mem_wr_data_d    = data_arr[win_idx];
          mem_wr_rd_d      = req_wr_rd[win_idx];
          state_d          = S_ISSUE;
`ifdef MEM_ARB_LOCK_EN
          if (win_idx != owner_q) lock_cnt_d = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (op_wr_q) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else begin
          rd_cnt_d = CNT_W'(RD_LAT - 1);
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rd_cnt_q == '0) begin
          rd_data_d = mem_rd_data;
          state_d   = S_RD_DONE;
        end else begin
          rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
      end
      S_RD_DONE: begin
        complete = 1'b1;
        rsp_d    = rd_data_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      ack_d[owner_q] = 1'b1;
`ifdef MEM_ARB_LOCK_EN
      if (req_lock[owner_q] && lock_cnt_q < LOCK_W'(MAX_LOCK - 1)) begin
        ptr_d      = owner_q;
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end else begin
        ptr_d      = next_idx(owner_q);
        lock_cnt_d = '0;
      end
`else
      ptr_d = next_idx(owner_q);
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      op_wr_q       <= 1'b0;
      rd_cnt_q      <= '0;
      rd_data_q     <= '0;
      gnt_q         <= '0;
      ack_q         <= '0;
      rsp_q         <= '0;
      busy_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_rd_q   <= 1'b0;
      mem_wr_data_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      op_wr_q       <= op_wr_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_data_q     <= rd_data_d;
      gnt_q         <= gnt_d;
      ack_q         <= ack_d;
      rsp_q         <= rsp_d;
      busy_q        <= busy_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_rd_q   <= mem_wr_rd_d;
      mem_wr_data_q <= mem_wr_data_d;
`ifdef MEM_ARB_LOCK_EN
      lock_cnt_q    <= lock_cnt_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign rsp_rd_data = rsp_q;
  assign busy        = busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_rd   = mem_wr_rd_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed steps plus randomized round-robin traffic checked
// against a transaction-level model (grant order and a shadow memory).
module tb_mem_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr_rd;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wr_data;
`ifdef MEM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rsp_rd_data;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_wr_rd;
  logic [DATA_W-1:0]         mem_wr_data;
  logic [DATA_W-1:0]         mem_rd_data;

  int n_asserts = 0;
  int n_fail    = 0;

  logic              op_f   [NUM_REQ];
  logic [ADDR_W-1:0] addr_f [NUM_REQ];
  logic [DATA_W-1:0] data_f [NUM_REQ];

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
`ifdef MEM_ARB_LOCK_EN
    ,
    .MAX_LOCK(2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_wr_rd   (req_wr_rd),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
`ifdef MEM_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .gnt         (gnt),
    .ack         (ack),
    .rsp_rd_data (rsp_rd_data),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_wr_rd   (mem_wr_rd),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Single-port memory: synchronous write, read data valid RD_LAT cycles later.
  logic [DATA_W-1:0] mem  [1<<ADDR_W];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_wr_rd) mem[mem_addr] <= mem_wr_data;
    pipe[0] <= mem[mem_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rd_data = pipe[RD_LAT-1];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_wr_rd[i]                 = op_f[i];
      req_addr[i*ADDR_W +: ADDR_W] = addr_f[i];
      req_wr_data[i*DATA_W +: DATA_W] = data_f[i];
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_gnt"},         32'(gnt),         0);
    check({pfx, "_ack"},         32'(ack),         0);
    check({pfx, "_rsp"},         32'(rsp_rd_data), 0);
    check({pfx, "_busy"},        32'(busy),        0);
    check({pfx, "_mem_addr"},    32'(mem_addr),    0);
    check({pfx, "_mem_wr_rd"},   32'(mem_wr_rd),   0);
    check({pfx, "_mem_wr_data"}, 32'(mem_wr_data), 0);
  endtask

  // Wait (bounded) for the next ack pulse; cyc counts negedges waited.
  task automatic wait_ack(input int budget, output logic [NUM_REQ-1:0] a, output int cyc);
    a   = '0;
    cyc = 0;
    while (a == '0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      a = ack;
    end
    n_asserts++;
    assert (a != '0) else begin
      n_fail++;
      $error("FAIL ack_timeout: observed no ack within %0d cycles, required an ack", budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
`ifdef MEM_ARB_LOCK_EN
    req_lock = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] act, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (act[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return 0;
  endfunction

  // Active requesters hold req continuously; every completion re-requests
  // with fresh random fields. Model: strict rotation over the active set,
  // reads return the last value written to that address.
  task automatic run_random(input logic [NUM_REQ-1:0] active, input int n_txn);
    logic [DATA_W-1:0] shadow [1<<ADDR_W];
    logic              sv     [1<<ADDR_W];
    int                e;
    int                done;
    int                cyc;
    do_reset();
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      sv[a]     = 1'b0;
      shadow[a] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      op_f[i]   = 1'($urandom_range(0, 1));
      addr_f[i] = ADDR_W'($urandom_range(0, 7));
      data_f[i] = DATA_W'($urandom);
    end
    drive_fields();
    req  = active;
    e    = pick(active, 0);
    done = 0;
    cyc  = 0;
    while (done < n_txn && cyc < n_txn * 12) begin
      @(negedge clk);
      cyc++;
      if (mem_wr_rd) begin
        check("rnd_wr_op",   32'(op_f[e]),     1);
        check("rnd_wr_addr", 32'(mem_addr),    32'(addr_f[e]));
        check("rnd_wr_data", 32'(mem_wr_data), 32'(data_f[e]));
        check("rnd_wr_gnt",  32'(gnt),         32'(1 << e));
      end
      if (ack != '0) begin
        check("rnd_ack_owner", 32'(ack), 32'(1 << e));
        check("rnd_ack_gnt",   32'(gnt), 32'(1 << e));
        if (op_f[e]) begin
          shadow[addr_f[e]] = data_f[e];
          sv[addr_f[e]]     = 1'b1;
        end else if (sv[addr_f[e]]) begin
          check("rnd_rd_data", 32'(rsp_rd_data), 32'(shadow[addr_f[e]]));
        end
        op_f[e]   = 1'($urandom_range(0, 1));
        addr_f[e] = ADDR_W'($urandom_range(0, 7));
        data_f[e] = DATA_W'($urandom);
        drive_fields();
        e = pick(active, (e + 1) % NUM_REQ);
        done++;
      end
    end
    n_asserts++;
    assert (done == n_txn) else begin
      n_fail++;
      $error("FAIL rnd_timeout: observed %0d transactions, required %0d", done, n_txn);
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    logic [NUM_REQ-1:0] a;
    int                 cyc;

    rst = 1'b0;
    req = '0;
`ifdef MEM_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      op_f[i]   = 1'b0;
      addr_f[i] = '0;
      data_f[i] = '0;
    end
    drive_fields();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Requester 0 writes 0xA5 to address 3.
    op_f[0] = 1'b1; addr_f[0] = 4'd3; data_f[0] = 8'hA5;
    drive_fields();
    req[0] = 1'b1;
    @(negedge clk);
    check("wr_issue_wr_rd", 32'(mem_wr_rd),   1);
    check("wr_issue_addr",  32'(mem_addr),    3);
    check("wr_issue_data",  32'(mem_wr_data), 32'h A5);
    check("wr_issue_gnt",   32'(gnt),         32'b0001);
    check("wr_issue_busy",  32'(busy),        1);
    check("wr_issue_ack",   32'(ack),         0);
    wait_ack(10, a, cyc);
    check("wr_latency",     32'(1 + cyc),     2);
    check("wr_ack",         32'(a),           32'b0001);
    check("wr_after_wr_rd", 32'(mem_wr_rd),   0);
    req[0] = 1'b0;
    @(negedge clk);
    check("wr_gnt_clear",   32'(gnt),         0);
    check("wr_idle_busy",   32'(busy),        0);

    // Requester 2 reads address 3 back.
    op_f[2] = 1'b0; addr_f[2] = 4'd3;
    drive_fields();
    req[2] = 1'b1;
    @(negedge clk);
    check("rd_issue_gnt",   32'(gnt),         32'b0100);
    check("rd_issue_wr_rd", 32'(mem_wr_rd),   0);
    check("rd_issue_addr",  32'(mem_addr),    3);
    wait_ack(20, a, cyc);
    check("rd_latency",     32'(1 + cyc),     32'(RD_LAT + 3));
    check("rd_ack",         32'(a),           32'b0100);
    check("rd_data",        32'(rsp_rd_data), 32'h A5);
    check("rd_ack_gnt",     32'(gnt),         32'b0100);
    req[2] = 1'b0;
    @(negedge clk);
    check("rd_rsp_clear",   32'(rsp_rd_data), 0);

    // Requester 1 writes 0x3C to address 5, leaving the pointer at 2.
    op_f[1] = 1'b1; addr_f[1] = 4'd5; data_f[1] = 8'h3C;
    drive_fields();
    req[1] = 1'b1;
    wait_ack(10, a, cyc);
    check("ptr_setup_ack",  32'(a),           32'b0010);
    req[1] = 1'b0;
    @(negedge clk);

    // With the pointer at 2, req[1] and req[3] rise together: 3 then 1.
    op_f[1] = 1'b0; addr_f[1] = 4'd5;
    op_f[3] = 1'b1; addr_f[3] = 4'd6; data_f[3] = 8'h5A;
    drive_fields();
    req = 4'b1010;
    wait_ack(10, a, cyc);
    check("ptr2_first",     32'(a),           32'b1000);
    req[3] = 1'b0;
    wait_ack(20, a, cyc);
    check("ptr2_second",    32'(a),           32'b0010);
    check("ptr2_rd_data",   32'(rsp_rd_data), 32'h 3C);
    req[1] = 1'b0;
    @(negedge clk);

    // Reset during RD_WAIT of a read by requester 2; req[0] also pending.
    op_f[2] = 1'b0; addr_f[2] = 4'd6;
    op_f[0] = 1'b1; addr_f[0] = 4'd7; data_f[0] = 8'h77;
    drive_fields();
    req = 4'b0101;
    @(negedge clk);
    check("rstrd_gnt",      32'(gnt),         32'b0100);
    @(negedge clk);
    check("rstrd_wait_busy", 32'(busy),       1);
    check("rstrd_wait_ack", 32'(ack),         0);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("rstrd");
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_no_ack",   32'(ack),         0);
    check("rstrd_regrant",  32'(gnt),         32'b0001);
    wait_ack(10, a, cyc);
    check("rstrd_first",    32'(a),           32'b0001);
    req[0] = 1'b0;
    wait_ack(20, a, cyc);
    check("rstrd_second",   32'(a),           32'b0100);
    check("rstrd_rd_data",  32'(rsp_rd_data), 32'h 5A);
    req[2] = 1'b0;
    @(negedge clk);

    // All four continuously active with mixed ops, then random subsets.
    run_random(4'b1111, 24);
    run_random(NUM_REQ'($urandom_range(1, 15)), 12);
    run_random(NUM_REQ'($urandom_range(1, 15)), 12);

`ifdef MEM_ARB_LOCK_EN
    // Requester 1 holds req and req_lock against requester 2: grants 1,1,2.
    do_reset();
    op_f[1] = 1'b1; addr_f[1] = 4'd1; data_f[1] = 8'h11;
    op_f[2] = 1'b1; addr_f[2] = 4'd2; data_f[2] = 8'h22;
    drive_fields();
    req_lock = 4'b0010;
    req      = 4'b0110;
    wait_ack(10, a, cyc);
    check("lock_g0", 32'(a), 32'b0010);
    wait_ack(10, a, cyc);
    check("lock_g1", 32'(a), 32'b0010);
    wait_ack(10, a, cyc);
    check("lock_g2", 32'(a), 32'b0100);
    req      = '0;
    req_lock = '0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
